// File: rtl/serial_word_pkg.sv
`default_nettype none
// ==== serial_word_pkg : shared types and constants for serial_word_tx (rev 1.0) ====
package serial_word_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } tx_state_t;

    localparam int GAP_MAX   = 15;
    localparam int GAP_CNT_W = 4;

    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_word_tx_shift_reg.sv
`default_nettype none
// ==== tx_shift_reg : loadable shifter, zero-filled so the serial bit idles low (rev 1.0) ====
module tx_shift_reg #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] d,
    output logic             q_bit
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_shifted;

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_shifted = {r_q[WIDTH-2:0], 1'b0};
            assign q_bit     = r_q[WIDTH-1];
        end else begin : g_lsb_first
            assign w_shifted = {1'b0, r_q[WIDTH-1:1]};
            assign q_bit     = r_q[0];
        end
    endgenerate

    // Load wins over shift so a back-to-back word replaces the finished one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (load) begin
            r_q <= d;
        end else if (shift) begin
            r_q <= w_shifted;
        end
    end

endmodule
`default_nettype wire

// File: rtl/serial_word_tx.sv
`default_nettype none
// ==== serial_word_tx : parallel-to-serial word transmitter with idle gap (rev 1.0) ====
module serial_word_tx
    import serial_word_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter int GAP       = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_out,
    output logic             ser_frame,
    output logic             ser_start,
    output logic             busy
);

    localparam int                     c_cnt_w    = cnt_width(WIDTH);
    localparam logic [c_cnt_w-1:0]     c_last     = c_cnt_w'(WIDTH - 1);
    localparam logic [GAP_CNT_W-1:0]   c_gap_load = (GAP > 0) ? GAP_CNT_W'(GAP - 1) : '0;

    tx_state_t              r_state;
    logic [c_cnt_w-1:0]     r_cnt;
    logic [GAP_CNT_W-1:0]   r_gap_cnt;
    logic                   r_frame;
    logic                   r_start;
    logic                   w_last;
    logic                   w_accept;

    assign w_last   = (r_state == ST_SHIFT) && (r_cnt == c_last);
    // Zero-bubble reload is only possible when no gap has to be inserted.
    assign in_ready = !rst && ((r_state == ST_IDLE) || ((GAP == 0) && w_last));
    assign w_accept = in_valid && in_ready;

    tx_shift_reg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift (
        .clk   (clk),
        .rst   (rst),
        .load  (w_accept),
        .shift (r_state == ST_SHIFT),
        .d     (in_data),
        .q_bit (ser_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_gap_cnt <= '0;
            r_frame   <= 1'b0;
            r_start   <= 1'b0;
        end else begin
            r_start <= w_accept;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state <= ST_SHIFT;
                        r_cnt   <= '0;
                        r_frame <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (r_cnt == c_last) begin
                        r_cnt <= '0;
                        if (w_accept) begin
                            r_frame <= 1'b1;
                        end else if (GAP == 0) begin
                            r_state <= ST_IDLE;
                            r_frame <= 1'b0;
                        end else begin
                            r_state   <= ST_GAP;
                            r_gap_cnt <= c_gap_load;
                            r_frame   <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (r_gap_cnt == '0) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ser_frame = r_frame;
    assign ser_start = r_start;
    assign busy      = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_serial_word_tx.sv
`default_nettype none
// ==== tb_serial_word_tx : directed self-checking bench for serial_word_tx (rev 1.0) ====
module tb_serial_word_tx;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // a: MSB first, GAP 0   b: MSB first, GAP 2   c: LSB first, GAP 0   d: MSB first, GAP 3
    logic [7:0] a_data = '0, b_data = '0, c_data = '0, d_data = '0;
    logic a_valid = 1'b0, b_valid = 1'b0, c_valid = 1'b0, d_valid = 1'b0;
    logic a_ready, a_out, a_frame, a_start, a_busy;
    logic b_ready, b_out, b_frame, b_start, b_busy;
    logic c_ready, c_out, c_frame, c_start, c_busy;
    logic d_ready, d_out, d_frame, d_start, d_busy;

    int total = 0;
    int bad   = 0;

    serial_word_tx #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP(0)) dut_a (
        .clk(clk), .rst(rst), .in_data(a_data), .in_valid(a_valid), .in_ready(a_ready),
        .ser_out(a_out), .ser_frame(a_frame), .ser_start(a_start), .busy(a_busy));
    serial_word_tx #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP(2)) dut_b (
        .clk(clk), .rst(rst), .in_data(b_data), .in_valid(b_valid), .in_ready(b_ready),
        .ser_out(b_out), .ser_frame(b_frame), .ser_start(b_start), .busy(b_busy));
    serial_word_tx #(.WIDTH(8), .MSB_FIRST(1'b0), .GAP(0)) dut_c (
        .clk(clk), .rst(rst), .in_data(c_data), .in_valid(c_valid), .in_ready(c_ready),
        .ser_out(c_out), .ser_frame(c_frame), .ser_start(c_start), .busy(c_busy));
    serial_word_tx #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP(3)) dut_d (
        .clk(clk), .rst(rst), .in_data(d_data), .in_valid(d_valid), .in_ready(d_ready),
        .ser_out(d_out), .ser_frame(d_frame), .ser_start(d_start), .busy(d_busy));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] w;
        logic [7:0] words [2];
        int c;

        // Reset state
        step(); step();
        chk("rst_ready_a", {31'd0, a_ready}, 0);
        chk("rst_ready_b", {31'd0, b_ready}, 0);
        chk("rst_outs_a", {28'd0, a_out, a_frame, a_start, a_busy}, 0);
        rst = 1'b0;
        step();

        // Single word, MSB first
        a_data = 8'hA5; a_valid = 1'b1;
        chk("t1_ready", {31'd0, a_ready}, 1);
        step();
        a_valid = 1'b0;
        w = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            chk("t1_bit", {31'd0, a_out}, {31'd0, w[7-i]});
            chk("t1_frame", {31'd0, a_frame}, 1);
            chk("t1_start", {31'd0, a_start}, (i == 0) ? 1 : 0);
            chk("t1_busy", {31'd0, a_busy}, 1);
            step();
        end
        chk("t1_end", {29'd0, a_out, a_frame, a_busy}, 0);
        chk("t1_ready_idle", {31'd0, a_ready}, 1);
        step();

        // Back-to-back, GAP 0
        words[0] = 8'hA5; words[1] = 8'h3C;
        a_data = words[0]; a_valid = 1'b1;
        chk("t2_ready0", {31'd0, a_ready}, 1);
        step();
        for (int cy = 1; cy <= 16; cy++) begin
            w = words[(cy - 1) / 8];
            chk("t2_ready", {31'd0, a_ready}, (cy == 8 || cy == 16) ? 1 : 0);
            chk("t2_frame", {31'd0, a_frame}, 1);
            chk("t2_start", {31'd0, a_start}, (cy == 1 || cy == 9) ? 1 : 0);
            chk("t2_bit", {31'd0, a_out}, {31'd0, w[7 - ((cy - 1) % 8)]});
            if (cy == 8) a_data = words[1];
            if (cy == 9) a_valid = 1'b0;
            step();
        end
        chk("t2_end", {30'd0, a_frame, a_busy}, 0);

        // GAP 2: 0xFF then 0x81 with valid held
        b_data = 8'hFF; b_valid = 1'b1;
        chk("t3_ready0", {31'd0, b_ready}, 1);
        step();
        b_data = 8'h81;
        for (int cy = 1; cy <= 8; cy++) begin
            chk("t3_w0_bit", {30'd0, b_out, b_frame}, 3);
            chk("t3_w0_ready", {31'd0, b_ready}, 0);
            step();
        end
        for (int cy = 9; cy <= 10; cy++) begin
            chk("t3_gap", {29'd0, b_out, b_frame, b_ready}, 0);
            chk("t3_gap_busy", {31'd0, b_busy}, 1);
            step();
        end
        chk("t3_idle_ready", {31'd0, b_ready}, 1);
        chk("t3_idle_busy", {31'd0, b_busy}, 0);
        step();
        b_valid = 1'b0;
        w = 8'h81;
        for (int i = 0; i < 8; i++) begin
            chk("t3_w1_bit", {31'd0, b_out}, {31'd0, w[7-i]});
            chk("t3_w1_start", {31'd0, b_start}, (i == 0) ? 1 : 0);
            step();
        end
        chk("t3_gap2", {30'd0, b_frame, b_out}, 0);

        // LSB first
        c_data = 8'h01; c_valid = 1'b1;
        step();
        c_valid = 1'b0;
        w = 8'h01;
        for (int i = 0; i < 8; i++) begin
            chk("t4_bit", {31'd0, c_out}, {31'd0, w[i]});
            chk("t4_frame", {31'd0, c_frame}, 1);
            step();
        end
        chk("t4_end", {30'd0, c_frame, c_busy}, 0);

        // Reset mid-frame
        a_data = 8'hC3; a_valid = 1'b1;
        step();
        a_valid = 1'b0;
        w = 8'hC3;
        for (int i = 0; i < 3; i++) begin
            chk("t5_bit", {31'd0, a_out}, {31'd0, w[7-i]});
            step();
        end
        rst = 1'b1;
        #1;
        chk("t5_ready_rst", {31'd0, a_ready}, 0);
        step();
        chk("t5_after_rst", {28'd0, a_out, a_frame, a_start, a_busy}, 0);
        rst = 1'b0;
        a_data = 8'h5A; a_valid = 1'b1;
        #1;
        chk("t5_ready", {31'd0, a_ready}, 1);
        step();
        a_valid = 1'b0;
        w = 8'h5A;
        for (int i = 0; i < 8; i++) begin
            chk("t5_bit2", {31'd0, a_out}, {31'd0, w[7-i]});
            chk("t5_start", {31'd0, a_start}, (i == 0) ? 1 : 0);
            chk("t5_frame", {31'd0, a_frame}, 1);
            step();
        end
        chk("t5_end", {30'd0, a_frame, a_busy}, 0);

        // Backpressure with GAP 3
        d_data = 8'h77; d_valid = 1'b1;
        step();
        d_data = 8'h12;
        c = 1;
        while (!d_ready && c < 40) begin
            chk("t6_wait_frame", {31'd0, d_frame}, (c <= 8) ? 1 : 0);
            chk("t6_wait_start", {31'd0, d_start}, (c == 1) ? 1 : 0);
            step();
            c++;
        end
        chk("t6_ready_cycle", c, 12);
        step();
        d_valid = 1'b0;
        w = 8'h12;
        for (int i = 0; i < 8; i++) begin
            chk("t6_bit", {31'd0, d_out}, {31'd0, w[7-i]});
            chk("t6_start", {31'd0, d_start}, (i == 0) ? 1 : 0);
            step();
        end
        for (int i = 0; i < 5; i++) begin
            chk("t6_no_dup", {29'd0, d_frame, d_start, d_out}, 0);
            step();
        end
        chk("t6_idle", {31'd0, d_busy}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
